// File: rtl/sc_game_pkg.sv
// rtl/sc_game_pkg.sv - shared state encoding and default timing for the Frogger game sequencer
// Default pause length targets 0.5 s at 50 MHz; the sim value keeps benches short.
package sc_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLAY     = 3'd1,
        ST_DYING    = 3'd2,
        ST_CHECK    = 3'd3,
        ST_NEXTLVL  = 3'd4,
        ST_GAMEOVER = 3'd5,
        ST_WIN      = 3'd6
    } gameState_t;

    localparam int HOLD_CYCLES_DEFAULT = 25000000;
    localparam int HOLD_CYCLES_SIM     = 4;
    localparam int HOLD_WIDTH_DEFAULT  = 25;
    localparam int LEVEL_WIDTH_DEFAULT = 2;
    localparam int MAX_LEVEL_DEFAULT   = 3;

    // Pause states are the only ones that run the hold counter.
    function automatic logic isPauseState(input gameState_t s);
        return (s == ST_DYING) || (s == ST_NEXTLVL);
    endfunction

endpackage

// File: rtl/sc_state_game_controller_if.sv
// rtl/sc_state_game_controller_if.sv - game event inputs and sequencer outputs bundled as one bus
// The controller takes the slave view; the rest of the core takes the master view.
interface sc_state_game_controller_if #(
    parameter int LEVEL_WIDTH = 2
);
    logic                   SC_StateGAME_start_InLow;
    logic                   SC_StateGAME_crash_InLow;
    logic                   SC_StateGAME_goal_InLow;
    logic [1:0]             SC_StateGAME_numLives_In;
    logic                   SC_StateGAME_lose_OutLow;
    logic                   SC_StateGAME_livesReset_OutHigh;
    logic                   SC_StateGAME_frogReset_OutHigh;
    logic [LEVEL_WIDTH-1:0] SC_StateGAME_level_Out;
    logic                   SC_StateGAME_run_OutHigh;
    logic                   SC_StateGAME_gameOver_OutHigh;
    logic                   SC_StateGAME_win_OutHigh;
    logic [2:0]             SC_StateGAME_state_Out;

    modport master (
        output SC_StateGAME_start_InLow, SC_StateGAME_crash_InLow,
               SC_StateGAME_goal_InLow, SC_StateGAME_numLives_In,
        input  SC_StateGAME_lose_OutLow, SC_StateGAME_livesReset_OutHigh,
               SC_StateGAME_frogReset_OutHigh, SC_StateGAME_level_Out,
               SC_StateGAME_run_OutHigh, SC_StateGAME_gameOver_OutHigh,
               SC_StateGAME_win_OutHigh, SC_StateGAME_state_Out
    );

    modport slave (
        input  SC_StateGAME_start_InLow, SC_StateGAME_crash_InLow,
               SC_StateGAME_goal_InLow, SC_StateGAME_numLives_In,
        output SC_StateGAME_lose_OutLow, SC_StateGAME_livesReset_OutHigh,
               SC_StateGAME_frogReset_OutHigh, SC_StateGAME_level_Out,
               SC_StateGAME_run_OutHigh, SC_StateGAME_gameOver_OutHigh,
               SC_StateGAME_win_OutHigh, SC_StateGAME_state_Out
    );
endinterface

// File: rtl/sc_counter_hold.sv
// rtl/sc_counter_hold.sv - reloadable down-counter timing the DYING and NEXTLVL pauses
// Load arms a HOLD_CYCLES-long pause; done is high on its final cycle.
module sc_counter_hold #(
    parameter int HOLD_CYCLES = 4,
    parameter int HOLD_WIDTH  = 25
) (
    input  logic SC_CounterHOLD_CLOCK_50,
    input  logic SC_CounterHOLD_RESET_InHigh,
    input  logic SC_CounterHOLD_load_InHigh,
    input  logic SC_CounterHOLD_enable_InHigh,
    output logic SC_CounterHOLD_done_OutHigh
);

    localparam logic [HOLD_WIDTH-1:0] LOAD_VALUE = HOLD_WIDTH'(HOLD_CYCLES - 1);

    logic [HOLD_WIDTH-1:0] count;

    always_ff @(posedge SC_CounterHOLD_CLOCK_50) begin
        if (SC_CounterHOLD_RESET_InHigh) begin
            count <= '0;
        end else if (SC_CounterHOLD_load_InHigh) begin
            count <= LOAD_VALUE;
        end else if (SC_CounterHOLD_enable_InHigh && (count != '0)) begin
            count <= count - HOLD_WIDTH'(1);
        end
    end

    assign SC_CounterHOLD_done_OutHigh = (count == '0);

endmodule

// File: rtl/sc_state_game_controller.sv
// rtl/sc_state_game_controller.sv - Frogger game sequencer: lives, levels, pauses and run gating
// Every output is a register loaded from the next-state decode, so pulses align with state entry.
module sc_state_game_controller
    import sc_game_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter int HOLD_WIDTH  = HOLD_WIDTH_DEFAULT,
    parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEFAULT,
    parameter int MAX_LEVEL   = MAX_LEVEL_DEFAULT
) (
    input  logic                    SC_StateGAME_CLOCK_50,
    input  logic                    SC_StateGAME_RESET_InHigh,
    sc_state_game_controller_if.slave gameBus
);

    gameState_t             state, stateNext;
    logic                   startPrev, startPrevValid, startEdge;
    logic                   holdDone, holdLoad, holdEnable;
    logic                   loseReg, loseNext;
    logic                   livesResetReg, livesResetNext;
    logic                   frogResetReg, frogResetNext;
    logic [LEVEL_WIDTH-1:0] levelReg, levelNext;
    logic                   runReg, gameOverReg, winReg;
    logic                   livesZero;

    // startPrevValid blocks a button held low through reset from looking like a fresh press.
    assign startEdge = startPrevValid && startPrev && !gameBus.SC_StateGAME_start_InLow;
    assign livesZero = (gameBus.SC_StateGAME_numLives_In == 2'd0);

    assign holdLoad   = (stateNext != state);
    assign holdEnable = isPauseState(state);

    sc_counter_hold #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .HOLD_WIDTH  (HOLD_WIDTH)
    ) u_hold (
        .SC_CounterHOLD_CLOCK_50      (SC_StateGAME_CLOCK_50),
        .SC_CounterHOLD_RESET_InHigh  (SC_StateGAME_RESET_InHigh),
        .SC_CounterHOLD_load_InHigh   (holdLoad),
        .SC_CounterHOLD_enable_InHigh (holdEnable),
        .SC_CounterHOLD_done_OutHigh  (holdDone)
    );

    always_comb begin
        stateNext      = state;
        loseNext       = 1'b1;
        livesResetNext = 1'b0;
        frogResetNext  = 1'b0;
        levelNext      = levelReg;
        case (state)
            ST_IDLE, ST_GAMEOVER, ST_WIN: begin
                if (startEdge) begin
                    stateNext      = ST_PLAY;
                    livesResetNext = 1'b1;
                    frogResetNext  = 1'b1;
                    levelNext      = '0;
                end
            end
            ST_PLAY: begin
                // Crash outranks goal; a zero-lives crash must not wrap the lives register.
                if (!gameBus.SC_StateGAME_crash_InLow) begin
                    stateNext = ST_DYING;
                    loseNext  = livesZero;
                end else if (!gameBus.SC_StateGAME_goal_InLow) begin
                    stateNext = ST_NEXTLVL;
                end
            end
            ST_DYING: begin
                if (holdDone) begin
                    stateNext = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (livesZero) begin
                    stateNext = ST_GAMEOVER;
                end else begin
                    stateNext     = ST_PLAY;
                    frogResetNext = 1'b1;
                end
            end
            ST_NEXTLVL: begin
                if (holdDone) begin
                    if (levelReg == LEVEL_WIDTH'(MAX_LEVEL)) begin
                        stateNext = ST_WIN;
                    end else begin
                        stateNext     = ST_PLAY;
                        frogResetNext = 1'b1;
                        levelNext     = levelReg + LEVEL_WIDTH'(1);
                    end
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SC_StateGAME_CLOCK_50) begin
        if (SC_StateGAME_RESET_InHigh) begin
            state          <= ST_IDLE;
            loseReg        <= 1'b1;
            livesResetReg  <= 1'b0;
            frogResetReg   <= 1'b0;
            levelReg       <= '0;
            runReg         <= 1'b0;
            gameOverReg    <= 1'b0;
            winReg         <= 1'b0;
            startPrev      <= 1'b1;
            startPrevValid <= 1'b0;
        end else begin
            state          <= stateNext;
            loseReg        <= loseNext;
            livesResetReg  <= livesResetNext;
            frogResetReg   <= frogResetNext;
            levelReg       <= levelNext;
            runReg         <= (stateNext == ST_PLAY);
            gameOverReg    <= (stateNext == ST_GAMEOVER);
            winReg         <= (stateNext == ST_WIN);
            startPrev      <= gameBus.SC_StateGAME_start_InLow;
            startPrevValid <= 1'b1;
        end
    end

    assign gameBus.SC_StateGAME_lose_OutLow        = loseReg;
    assign gameBus.SC_StateGAME_livesReset_OutHigh = livesResetReg;
    assign gameBus.SC_StateGAME_frogReset_OutHigh  = frogResetReg;
    assign gameBus.SC_StateGAME_level_Out          = levelReg;
    assign gameBus.SC_StateGAME_run_OutHigh        = runReg;
    assign gameBus.SC_StateGAME_gameOver_OutHigh   = gameOverReg;
    assign gameBus.SC_StateGAME_win_OutHigh        = winReg;
    assign gameBus.SC_StateGAME_state_Out          = state;

endmodule

// File: tb/tb_sc_state_game_controller.sv
// tb/tb_sc_state_game_controller.sv - self-checking bench for the Frogger game sequencer
// A behavioural lives register closes the loop; expected lose pulses go through a scoreboard queue.
module tb_sc_state_game_controller;
    import sc_game_pkg::*;

    localparam int HC = HOLD_CYCLES_SIM;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    sc_state_game_controller_if #(.LEVEL_WIDTH(2)) gameBus ();

    sc_state_game_controller #(
        .HOLD_CYCLES (HC),
        .HOLD_WIDTH  (25),
        .LEVEL_WIDTH (2),
        .MAX_LEVEL   (3)
    ) dut (
        .SC_StateGAME_CLOCK_50     (clk),
        .SC_StateGAME_RESET_InHigh (rst),
        .gameBus                   (gameBus)
    );

    // Lives register model: wraps 0 -> 3 on decrement, restored by livesReset.
    logic [1:0] livesReg = 2'd3;
    logic       livesForceZero = 1'b0;
    always @(posedge clk) begin
        if (gameBus.SC_StateGAME_livesReset_OutHigh === 1'b1) livesReg <= 2'd3;
        else if (gameBus.SC_StateGAME_lose_OutLow === 1'b0)  livesReg <= livesReg - 2'd1;
    end
    assign gameBus.SC_StateGAME_numLives_In = livesForceZero ? 2'd0 : livesReg;

    logic [2:0] st;
    logic [1:0] lvl, lives;
    logic       lose, lr, fr, run, go, win;
    assign st    = gameBus.SC_StateGAME_state_Out;
    assign lvl   = gameBus.SC_StateGAME_level_Out;
    assign lives = gameBus.SC_StateGAME_numLives_In;
    assign lose  = gameBus.SC_StateGAME_lose_OutLow;
    assign lr    = gameBus.SC_StateGAME_livesReset_OutHigh;
    assign fr    = gameBus.SC_StateGAME_frogReset_OutHigh;
    assign run   = gameBus.SC_StateGAME_run_OutHigh;
    assign go    = gameBus.SC_StateGAME_gameOver_OutHigh;
    assign win   = gameBus.SC_StateGAME_win_OutHigh;

    int tests = 0;
    int fails = 0;
    int sbQ[$];
    int expLives = 3;

    // One clock, sampled 1 ns after the edge; every lose pulse is matched to a queued expectation.
    task automatic tick();
        int exp;
        @(posedge clk);
        #1;
        if (lose === 1'b0) begin
            tests++;
            if (sbQ.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_lose: lose=0 with none expected, lives=%0d state=%0d", lives, st);
            end else begin
                exp = sbQ.pop_front();
                if (int'(lives) !== exp) begin
                    fails++;
                    $display("FAIL sb_lose_lives: lives at pulse %0d, expected %0d", lives, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gameBus.SC_StateGAME_start_InLow = 1'b1;
        gameBus.SC_StateGAME_crash_InLow = 1'b1;
        gameBus.SC_StateGAME_goal_InLow  = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({st, lose, lr, fr, lvl, run, go, win} !== {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: st=%0d lose=%b lr=%b fr=%b lvl=%0d run=%b go=%b win=%b, expected st=0 lose=1 others 0",
                     st, lose, lr, fr, lvl, run, go, win);
        end
    endtask

    task automatic test_start();
        gameBus.SC_StateGAME_start_InLow = 1'b0;
        tick();
        gameBus.SC_StateGAME_start_InLow = 1'b1;
        tests++;
        if ({st, lr, fr, run, lvl, go, win} !== {3'd1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL start_entry: st=%0d lr=%b fr=%b run=%b lvl=%0d go=%b win=%b, expected st=1 lr=1 fr=1 run=1 lvl=0",
                     st, lr, fr, run, lvl, go, win);
        end
        tick();
        tests++;
        if ({lr, fr, lives, st} !== {1'b0, 1'b0, 2'd3, 3'd1}) begin
            fails++;
            $display("FAIL start_pulse_len: lr=%b fr=%b lives=%0d st=%0d, expected lr=0 fr=0 lives=3 st=1", lr, fr, lives, st);
        end
        expLives = 3;
    endtask

    // Crash (optionally with goal) from PLAY, held through the whole pause and CHECK.
    task automatic do_crash(input bit expectLose, input bit withGoal);
        logic [1:0] lvlBefore;
        lvlBefore = lvl;
        if (expectLose) begin
            sbQ.push_back(expLives);
            expLives--;
        end
        gameBus.SC_StateGAME_crash_InLow = 1'b0;
        gameBus.SC_StateGAME_goal_InLow  = withGoal ? 1'b0 : 1'b1;
        for (int i = 0; i < HC; i++) begin
            tick();
            gameBus.SC_StateGAME_goal_InLow = 1'b1;
            tests++;
            if ({st, run, lvl} !== {3'd2, 1'b0, lvlBefore}) begin
                fails++;
                $display("FAIL dying_hold[%0d]: st=%0d run=%b lvl=%0d, expected st=2 run=0 lvl=%0d", i, st, run, lvl, lvlBefore);
            end
        end
        tick();
        tests++;
        if (st !== 3'd3) begin
            fails++;
            $display("FAIL check_state: st=%0d, expected 3", st);
        end
        gameBus.SC_StateGAME_crash_InLow = 1'b1;
        tick();
        tests++;
        if (expLives == 0) begin
            if ({st, go, run, lives} !== {3'd5, 1'b1, 1'b0, 2'd0}) begin
                fails++;
                $display("FAIL game_over_entry: st=%0d go=%b run=%b lives=%0d, expected st=5 go=1 run=0 lives=0", st, go, run, lives);
            end
        end else if ({st, fr, run, lives} !== {3'd1, 1'b1, 1'b1, 2'(expLives)}) begin
            fails++;
            $display("FAIL respawn: st=%0d fr=%b run=%b lives=%0d, expected st=1 fr=1 run=1 lives=%0d", st, fr, run, lives, expLives);
        end
    endtask

    task automatic test_single_crash();
        do_crash(1'b1, 1'b0);
    endtask

    task automatic test_game_over();
        do_crash(1'b1, 1'b0);
        do_crash(1'b1, 1'b0);
        gameBus.SC_StateGAME_crash_InLow = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({st, go, run, lives} !== {3'd5, 1'b1, 1'b0, 2'd0}) begin
                fails++;
                $display("FAIL game_over_stays[%0d]: st=%0d go=%b run=%b lives=%0d, expected st=5 go=1 run=0 lives=0", i, st, go, run, lives);
            end
        end
        gameBus.SC_StateGAME_crash_InLow = 1'b1;
    endtask

    task automatic test_zero_lives();
        test_reset();
        test_start();
        livesForceZero = 1'b1;
        expLives = 0;
        do_crash(1'b0, 1'b0);
        livesForceZero = 1'b0;
    endtask

    task automatic test_crash_goal();
        test_reset();
        test_start();
        do_crash(1'b1, 1'b1);
    endtask

    task automatic test_levels();
        test_reset();
        test_start();
        for (int n = 0; n < 4; n++) begin
            gameBus.SC_StateGAME_goal_InLow = 1'b0;
            for (int i = 0; i < HC; i++) begin
                tick();
                gameBus.SC_StateGAME_goal_InLow = 1'b1;
                tests++;
                if ({st, run, lvl} !== {3'd4, 1'b0, 2'(n)}) begin
                    fails++;
                    $display("FAIL nextlvl_hold[%0d,%0d]: st=%0d run=%b lvl=%0d, expected st=4 run=0 lvl=%0d", n, i, st, run, lvl, n);
                end
            end
            tick();
            tests++;
            if (n < 3) begin
                if ({st, fr, run, lvl} !== {3'd1, 1'b1, 1'b1, 2'(n + 1)}) begin
                    fails++;
                    $display("FAIL level_up[%0d]: st=%0d fr=%b run=%b lvl=%0d, expected st=1 fr=1 run=1 lvl=%0d", n, st, fr, run, lvl, n + 1);
                end
            end else if ({st, win, run, lvl} !== {3'd6, 1'b1, 1'b0, 2'd3}) begin
                fails++;
                $display("FAIL win_entry: st=%0d win=%b run=%b lvl=%0d, expected st=6 win=1 run=0 lvl=3", st, win, run, lvl);
            end
        end
        gameBus.SC_StateGAME_start_InLow = 1'b0;
        tick();
        gameBus.SC_StateGAME_start_InLow = 1'b1;
        tests++;
        if ({st, lvl, lr, fr, win} !== {3'd1, 2'd0, 1'b1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL win_restart: st=%0d lvl=%0d lr=%b fr=%b win=%b, expected st=1 lvl=0 lr=1 fr=1 win=0", st, lvl, lr, fr, win);
        end
        tick();
    endtask

    task automatic test_reset_mid_dying();
        sbQ.push_back(expLives);
        expLives--;
        gameBus.SC_StateGAME_crash_InLow = 1'b0;
        tick(); tick();
        tests++;
        if (st !== 3'd2) begin
            fails++;
            $display("FAIL mid_dying_pre: st=%0d, expected 2", st);
        end
        rst = 1'b1;
        gameBus.SC_StateGAME_start_InLow = 1'b0;
        tick();
        rst = 1'b0;
        gameBus.SC_StateGAME_crash_InLow = 1'b1;
        tests++;
        if ({st, lose, run, fr, lr} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL mid_dying_reset: st=%0d lose=%b run=%b fr=%b lr=%b, expected st=0 lose=1 run=0 fr=0 lr=0", st, lose, run, fr, lr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({st, run} !== {3'd0, 1'b0}) begin
                fails++;
                $display("FAIL held_start_ignored[%0d]: st=%0d run=%b, expected st=0 run=0", i, st, run);
            end
        end
        gameBus.SC_StateGAME_start_InLow = 1'b1;
        tick();
        test_start();
        do_crash(1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_start();
        test_single_crash();
        test_game_over();
        test_zero_lives();
        test_crash_goal();
        test_levels();
        test_reset_mid_dying();
        tick();
        tests++;
        if (sbQ.size() != 0) begin
            fails++;
            $display("FAIL sb_missing_lose: %0d expected lose pulses never seen, expected 0", sbQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sc_state_game_controller.md
Name: sc_state_game_controller

Overview:
- Top-level game sequencer for the Frogger core.
- Consumes the collision, goal and start-button events and drives the lives register's active-low lose input.
- Also drives its reset, the frog-position reset, the level counter and the obstacle run-enable.
- Guarantees exactly one life is lost per crash and gates gameplay during death and level-transition pauses.

Parameters:
- HOLD_CYCLES, 25000000, pause length in clocks for DYING and NEXTLVL (0.5 s at 50 MHz); must be >= 2.
- HOLD_WIDTH, 25, width of the hold counter; must satisfy 2^HOLD_WIDTH > HOLD_CYCLES.
- LEVEL_WIDTH, 2, width of the level output.
- MAX_LEVEL, 3, last level; completing it ends the game as a win.

Ports:
- SC_StateGAME_CLOCK_50  in  1  system clock, 50 MHz.
- SC_StateGAME_RESET_InHigh  in  1  reset, synchronous, active-high.
- SC_StateGAME_start_InLow  in  1  start button, active low, already debounced.
- SC_StateGAME_crash_InLow  in  1  frog/obstacle collision, active low, level-sensitive.
- SC_StateGAME_goal_InLow  in  1  frog reached the top row, active low.
- SC_StateGAME_numLives_In  in  2  current lives from the lives register.
- SC_StateGAME_lose_OutLow  out  1  decrement request to the lives register, active low.
- SC_StateGAME_livesReset_OutHigh  out  1  one-cycle pulse that restores the lives register to 3.
- SC_StateGAME_frogReset_OutHigh  out  1  one-cycle pulse that returns the frog to its start position.
- SC_StateGAME_level_Out  out  LEVEL_WIDTH  current level, 0-based.
- SC_StateGAME_run_OutHigh  out  1  obstacle movement enable.
- SC_StateGAME_gameOver_OutHigh  out  1  high while in GAMEOVER.
- SC_StateGAME_win_OutHigh  out  1  high while in WIN.
- SC_StateGAME_state_Out  out  3  state encoding, for debug and display.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE, lose=1, livesReset=0, frogReset=0, level=0, run=0, gameOver=0, win=0, hold counter=0, start-edge register=1.
- Start button: only its falling edge acts (registered previous sample; event = prev 1, now 0). A held button never retriggers.
- Encoding: IDLE=0, PLAY=1, DYING=2, CHECK=3, NEXTLVL=4, GAMEOVER=5, WIN=6. Code 7 is illegal and recovers to IDLE on the next clock.
- IDLE: run=0.
  - On start edge -> PLAY.
  - Same cycle as that transition: livesReset=1, frogReset=1, level=0 (each pulse lasts exactly one cycle).
- PLAY: run=1.
  - crash low -> DYING; lose=0 for exactly the one cycle following the transition edge.
  - Else goal low -> NEXTLVL.
  - Crash and goal in the same cycle: crash wins.
- DYING: run=0.
  - Hold counter counts 0..HOLD_CYCLES-1, then -> CHECK.
  - crash and goal are ignored, so a crash still asserted yields no extra lose pulse.
- CHECK: single cycle. The lives value is stable by now because HOLD_CYCLES >= 2.
  - numLives_In == 0 -> GAMEOVER.
  - Otherwise -> PLAY with a frogReset pulse.
- NEXTLVL: run=0. Hold for HOLD_CYCLES.
  - If level == MAX_LEVEL -> WIN.
  - Otherwise level increments by 1 (no wrap) -> PLAY with a frogReset pulse.
- GAMEOVER / WIN: run=0; the matching flag is high.
  - On start edge -> PLAY with livesReset, frogReset, and level cleared to 0.
- Lives wrap: the lives register wraps 0 -> 3 on a decrement. The controller never issues lose while numLives_In == 0. If crash occurs in PLAY with lives already 0, it goes DYING -> CHECK -> GAMEOVER with no lose pulse.
- Hold counter: cleared on every state entry.
- Reset mid-operation: reset wins over everything. It clears the hold counter and any pending pulse within one clock.

Decomposition:
- Shared package sc_game_pkg:
  - state encoding constants;
  - default HOLD_CYCLES, plus a simulation override value of 4;
  - MAX_LEVEL.
- One natural sub-module: sc_counter_hold, a synchronous clear/enable down-counter with a done flag, sized by HOLD_WIDTH. It is reused for the DYING and NEXTLVL pauses.

Test Plan (HOLD_CYCLES=4):
- Reset, then start pulsed low for 1 cycle -> livesReset=1 and frogReset=1 for one cycle; state=1; run=1; level=0.
- In PLAY with lives=3, crash held low for 20 cycles -> exactly one lose=0 cycle; lives reads 2; state 2 for 4 cycles, then CHECK, then PLAY with a frogReset pulse.
- Three crashes separated by returns to PLAY -> lives 3->2->1->0; after the third: state=5, gameOver=1, run=0; no fourth lose pulse; lives never wraps to 3.
- crash and goal low in the same PLAY cycle -> DYING entered, lose pulse issued, level unchanged.
- Four goals -> level 0->1->2->3, then WIN with win=1. A start edge then gives level=0, livesReset pulse, state=1.
- Assert reset for 1 cycle while in DYING mid-hold -> next cycle state=0, lose=1, run=0, counter=0; start held low across reset release does not start a game.
